// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode constants, framing FSM state
// encoding (shared with the receiver) and a parity helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Turns the XOR of the data bits into the transmitted parity bit.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read: rd_data always presents the
// oldest entry, so a pop and its data use happen on the same edge.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_wr, do_rd;

    assign full    = (count_q == DEPTH_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    // Next pointers and occupancy; simultaneous push and pop leave count alone.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr && !do_rd)      count_d = count_q + 1'b1;
        else if (!do_wr && do_rd) count_d = count_q - 1'b1;
    end

    // Pointer/count registers; reset flushes the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Parametrised UART transmitter with a transmit FIFO. Frames are sent
// back to back: the next word is popped on the final stop-bit edge.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 12000000 / 9600,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          data_valid,
    input  logic [DATA_BITS-1:0]          byte_data,
    output logic                          ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          tx,
    output logic                          done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
        $error("uart_tx_fifo: parameter out of range");
    end

    uart_state_e          state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 fifo_pop, fifo_empty, fifo_full;
    logic [DATA_BITS-1:0] fifo_rd_data;
    logic                 bit_end, last_stop, load;

    assign ready = ~fifo_full;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (data_valid && ready),
        .wr_data (byte_data),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Framing FSM next-state: bit timing, shifting, parity and FIFO pops.
    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fifo_pop  = 1'b0;
        load      = 1'b0;
        bit_end   = (clk_cnt_q == LAST_CNT);
        last_stop = (bit_idx_q == LAST_STOP);

        if (state_q != ST_IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == LAST_DATA) begin
                        bit_idx_d = '0;
                        if (PARITY != PARITY_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d   = ST_STOP;
                    bit_idx_d = '0;
                    tx_d      = 1'b1;
                end
            end
            ST_STOP: begin
                // done is registered, so raise it one edge early to land on the last cycle
                if (last_stop && clk_cnt_q == PRE_LAST) done_d = 1'b1;
                if (bit_end) begin
                    if (!last_stop) begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_rd_data;
            parity_d  = parity_bit(^fifo_rd_data, PARITY);
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_START;
            clk_cnt_d = '0;
        end
    end

    // Framing FSM registers; reset returns the line to idle-high at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8E1, 7O2, 8N1) each checked
// every cycle against a frame-level reference model.
module tb_uart_tx_fifo;

    localparam int CLKS  = 4;
    localparam int DEPTH = 4;
    localparam int NCFG  = 3;

    logic       clk;
    logic       rst;
    logic       dv      [NCFG];
    logic [7:0] bd      [NCFG];
    logic       tx_w    [NCFG];
    logic       busy_w  [NCFG];
    logic       done_w  [NCFG];
    logic       ready_w [NCFG];
    logic [2:0] cnt_w   [NCFG];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int DB  = (gi == 1) ? 7 : 8;
        localparam int PAR = (gi == 0) ? 1 : ((gi == 1) ? 2 : 0);
        localparam int SB  = (gi == 1) ? 2 : 1;

        logic [DB-1:0] din;
        assign din = bd[gi][DB-1:0];

        uart_tx_fifo #(
            .CLKS_PER_BIT (CLKS),
            .DATA_BITS    (DB),
            .PARITY       (PAR),
            .STOP_BITS    (SB),
            .FIFO_DEPTH   (DEPTH)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .data_valid (dv[gi]),
            .byte_data  (din),
            .ready      (ready_w[gi]),
            .fifo_count (cnt_w[gi]),
            .busy       (busy_w[gi]),
            .tx         (tx_w[gi]),
            .done       (done_w[gi])
        );

        // Reference: queue of accepted words plus the per-cycle line values
        // still to come for the frame in flight.
        logic [DB-1:0] words    [$];
        logic          exp_line [$];
        logic          exp_tx   = 1'b1;
        logic          exp_busy = 1'b0;
        logic          exp_done = 1'b0;
        logic          acc_m;
        logic          par_m;
        logic [DB-1:0] w_m;

        initial forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                words.delete();
                exp_line.delete();
                exp_tx   = 1'b1;
                exp_busy = 1'b0;
                exp_done = 1'b0;
            end else begin
                acc_m = dv[gi] && (words.size() < DEPTH);
                if (exp_line.size() == 0 && words.size() != 0) begin
                    w_m   = words.pop_front();
                    par_m = (PAR == 2);
                    for (int b = 0; b < DB; b++) par_m = par_m ^ w_m[b];
                    repeat (CLKS) exp_line.push_back(1'b0);
                    for (int b = 0; b < DB; b++) repeat (CLKS) exp_line.push_back(w_m[b]);
                    if (PAR != 0) repeat (CLKS) exp_line.push_back(par_m);
                    repeat (SB * CLKS) exp_line.push_back(1'b1);
                end
                if (acc_m) words.push_back(din);
                if (exp_line.size() != 0) begin
                    exp_tx   = exp_line.pop_front();
                    exp_busy = 1'b1;
                    exp_done = (exp_line.size() == 0);
                end else begin
                    exp_tx   = 1'b1;
                    exp_busy = 1'b0;
                    exp_done = 1'b0;
                end
            end
        end

        initial forever begin
            @(negedge clk);
            check_eq($sformatf("c%0d_tx", gi),    32'(tx_w[gi]),    32'(exp_tx));
            check_eq($sformatf("c%0d_busy", gi),  32'(busy_w[gi]),  32'(exp_busy));
            check_eq($sformatf("c%0d_done", gi),  32'(done_w[gi]),  32'(exp_done));
            check_eq($sformatf("c%0d_count", gi), 32'(cnt_w[gi]),   32'(words.size()));
            check_eq($sformatf("c%0d_ready", gi), 32'(ready_w[gi]), 32'(words.size() < DEPTH));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < NCFG; i++) dv[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NCFG; i++) begin
            dv[i] = 1'b0;
            bd[i] = 8'h00;
        end
        tick(3);
        for (int i = 0; i < NCFG; i++) begin
            check_eq($sformatf("rst_tx%0d", i),    32'(tx_w[i]),    32'd1);
            check_eq($sformatf("rst_busy%0d", i),  32'(busy_w[i]),  32'd0);
            check_eq($sformatf("rst_ready%0d", i), 32'(ready_w[i]), 32'd1);
            check_eq($sformatf("rst_count%0d", i), 32'(cnt_w[i]),   32'd0);
        end
        rst = 1'b0;
        tick(2);

        // 8E1 0xA5, 7O2 0x07, and 8N1 0x00 then 0xFF back to back
        dv[0] = 1'b1; bd[0] = 8'hA5;
        dv[1] = 1'b1; bd[1] = 8'h07;
        dv[2] = 1'b1; bd[2] = 8'h00;
        tick(1);
        check_eq("lat_tx0", 32'(tx_w[0]), 32'd1);
        dv[0] = 1'b0; dv[1] = 1'b0; bd[2] = 8'hFF;
        tick(1);
        check_eq("lat_tx0_low", 32'(tx_w[0]), 32'd0);
        check_eq("lat_tx1_low", 32'(tx_w[1]), 32'd0);
        dv[2] = 1'b0;
        tick(100);

        // Hold valid six cycles from idle: the sixth word meets a full FIFO
        for (int k = 1; k <= 6; k++) begin
            dv[2] = 1'b1;
            bd[2] = 8'(k);
            if (k == 6) begin
                check_eq("full_ready", 32'(ready_w[2]), 32'd0);
                check_eq("full_count", 32'(cnt_w[2]),   32'd4);
            end
            tick(1);
        end
        dv[2] = 1'b0;
        check_eq("full_after_count", 32'(cnt_w[2]), 32'd4);
        tick(230);

        // Reset in the middle of a frame with two words queued
        dv[2] = 1'b1; bd[2] = 8'h11; tick(1);
        bd[2] = 8'h22; tick(1);
        bd[2] = 8'h33; tick(1);
        dv[2] = 1'b0;
        check_eq("pre_rst_count", 32'(cnt_w[2]), 32'd2);
        tick(13);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_tx",    32'(tx_w[2]),   32'd1);
        check_eq("mid_rst_busy",  32'(busy_w[2]), 32'd0);
        check_eq("mid_rst_count", 32'(cnt_w[2]),  32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);
        dv[2] = 1'b1; bd[2] = 8'h3C; tick(1);
        dv[2] = 1'b0;
        tick(50);

        // Write on the same edge the FSM pops the only queued word
        dv[2] = 1'b1; bd[2] = 8'h5A; tick(1);
        bd[2] = 8'h12; tick(1);
        dv[2] = 1'b0;
        check_eq("wr_pop_count", 32'(cnt_w[2]),  32'd1);
        check_eq("wr_pop_busy",  32'(busy_w[2]), 32'd1);
        tick(90);

        // Random traffic with occasional resets
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NCFG; i++) begin
                dv[i] = ($urandom_range(0, (c < 1000) ? 7 : 60) == 0);
                bd[i] = 8'($urandom);
            end
            rst = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        idle_inputs();
        tick(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
